// File: rtl/fifo_camara.sv
// Single-clock byte FIFO between the camera/pattern source and its downstream reader.
// Define FIFO_CAMARA_FWFT_EN for first-word-fall-through reads; default is registered reads.
module fifo_camara #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              underflow
);

   localparam int unsigned Depth = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] PtrOne = {{ADDR_W{1'b0}}, 1'b1};

   logic [DATA_W-1:0] mem [Depth];
   logic [ADDR_W:0]   wr_ptr_q, rd_ptr_q;
   logic              overflow_q, underflow_q;
   logic              rd_acc, wr_acc;

   // The extra MSB on each pointer tells full apart from empty when the address bits match.
   always_comb begin
      empty  = (wr_ptr_q == rd_ptr_q);
      full   = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
               (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
      count  = wr_ptr_q - rd_ptr_q;
      rd_acc = rd_en & ~empty;
      wr_acc = wr_en & (~full | rd_acc);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr_q <= wr_ptr_q + PtrOne;
         if (rd_acc) rd_ptr_q <= rd_ptr_q + PtrOne;
         if (wr_en && !wr_acc) overflow_q <= 1'b1;
         if (rd_en && !rd_acc) underflow_q <= 1'b1;
      end
   end

   // Storage is deliberately not reset; stale words are unreachable once the pointers clear.
   always_ff @(posedge clock) begin
      if (wr_acc) mem[wr_ptr_q[ADDR_W-1:0]] <= wr_data;
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;

`ifdef FIFO_CAMARA_FWFT_EN
   // Head word is always presented; rd_en only acknowledges and pops it.
   assign rd_data  = mem[rd_ptr_q[ADDR_W-1:0]];
   assign rd_valid = ~empty;
`else
   logic [DATA_W-1:0] rd_data_q;
   logic              rd_valid_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_acc;
         if (rd_acc) rd_data_q <= mem[rd_ptr_q[ADDR_W-1:0]];
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_fifo_camara.sv
// Directed self-checking bench for fifo_camara in its default (registered read) build.
module tb_fifo_camara;

   logic       clock;
   logic       reset_n;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       rd_en;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       full;
   logic       empty;
   logic [4:0] count;
   logic       overflow;
   logic       underflow;

   int total = 0;
   int bad   = 0;

   fifo_camara #(
      .DATA_W(8),
      .ADDR_W(4)
   ) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .rd_en    (rd_en),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .overflow (overflow),
      .underflow(underflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one active edge and settle just after it.
   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset_n = 1'b0;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      wr_data = 8'h00;

      // Reset held while the request lines toggle.
      for (int i = 0; i < 4; i++) begin
         wr_en   = i[0];
         rd_en   = ~i[0];
         wr_data = 8'hA0 + 8'(i);
         cyc();
      end
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_rd_data", 32'(rd_data), 32'h00);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_underflow", 32'(underflow), 32'd0);
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      reset_n = 1'b1;
      cyc();

      // Pattern write then read back.
      wr_en = 1'b1;
      wr_data = 8'h0A; cyc();
      chk("pat_count1", 32'(count), 32'd1);
      wr_data = 8'h0C; cyc();
      wr_data = 8'h0E; cyc();
      wr_en = 1'b0;
      chk("pat_count3", 32'(count), 32'd3);
      chk("pat_not_empty", 32'(empty), 32'd0);
      chk("pat_no_valid", 32'(rd_valid), 32'd0);
      rd_en = 1'b1;
      cyc();
      chk("pat_rd0", 32'(rd_data), 32'h0A);
      chk("pat_valid0", 32'(rd_valid), 32'd1);
      chk("pat_count2", 32'(count), 32'd2);
      cyc();
      chk("pat_rd1", 32'(rd_data), 32'h0C);
      cyc();
      chk("pat_rd2", 32'(rd_data), 32'h0E);
      chk("pat_count0", 32'(count), 32'd0);
      chk("pat_empty", 32'(empty), 32'd1);
      rd_en = 1'b0;
      cyc();
      chk("pat_valid_drop", 32'(rd_valid), 32'd0);
      chk("pat_hold", 32'(rd_data), 32'h0E);

      // Fill to 16 words, then one rejected write.
      wr_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         wr_data = 8'(i);
         cyc();
      end
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_count", 32'(count), 32'd16);
      chk("fill_no_ovf", 32'(overflow), 32'd0);
      wr_data = 8'hFF;
      cyc();
      wr_en = 1'b0;
      chk("fill_overflow", 32'(overflow), 32'd1);
      chk("fill_count_hold", 32'(count), 32'd16);

      // Full with simultaneous read and write.
      wr_en   = 1'b1;
      wr_data = 8'h55;
      rd_en   = 1'b1;
      cyc();
      wr_en = 1'b0;
      chk("fs_count", 32'(count), 32'd16);
      chk("fs_full", 32'(full), 32'd1);
      chk("fs_rd", 32'(rd_data), 32'h00);
      chk("fs_valid", 32'(rd_valid), 32'd1);
      for (int i = 1; i <= 16; i++) begin
         cyc();
         chk($sformatf("fs_drain%0d", i), 32'(rd_data), (i < 16) ? 32'(i) : 32'h55);
      end
      rd_en = 1'b0;
      chk("fs_empty", 32'(empty), 32'd1);
      chk("fs_no_udf", 32'(underflow), 32'd0);

      // Reads against an empty FIFO.
      rd_en = 1'b1;
      cyc();
      rd_en = 1'b0;
      chk("emp_underflow", 32'(underflow), 32'd1);
      chk("emp_rd_hold", 32'(rd_data), 32'h55);
      chk("emp_no_valid", 32'(rd_valid), 32'd0);
      rd_en   = 1'b1;
      wr_en   = 1'b1;
      wr_data = 8'h33;
      cyc();
      rd_en = 1'b0;
      wr_en = 1'b0;
      chk("emp_wr_count", 32'(count), 32'd1);
      chk("emp_wr_no_valid", 32'(rd_valid), 32'd0);
      rd_en = 1'b1;
      cyc();
      rd_en = 1'b0;
      chk("emp_rd33", 32'(rd_data), 32'h33);
      chk("emp_rd33_valid", 32'(rd_valid), 32'd1);
      chk("emp_rd33_count", 32'(count), 32'd0);

      // Interleaved pairs cross the pointer wrap.
      for (int i = 0; i < 40; i++) begin
         wr_en   = 1'b1;
         wr_data = 8'(i);
         cyc();
         wr_en = 1'b0;
         rd_en = 1'b1;
         cyc();
         rd_en = 1'b0;
         chk($sformatf("wrap%0d", i), 32'(rd_data), 32'(i));
      end

      // Async reset with five words stored.
      wr_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         wr_data = 8'h80 + 8'(i);
         cyc();
      end
      wr_en = 1'b0;
      chk("ar_count5", 32'(count), 32'd5);
      reset_n = 1'b0;
      #2;
      chk("ar_count0", 32'(count), 32'd0);
      chk("ar_empty", 32'(empty), 32'd1);
      chk("ar_overflow", 32'(overflow), 32'd0);
      chk("ar_underflow", 32'(underflow), 32'd0);
      #2;
      reset_n = 1'b1;
      wr_en   = 1'b1;
      wr_data = 8'h99;
      cyc();
      wr_en = 1'b0;
      rd_en = 1'b1;
      cyc();
      rd_en = 1'b0;
      chk("ar_new_data", 32'(rd_data), 32'h99);
      chk("ar_new_count", 32'(count), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
